// File: rtl/dm_store_buffer.sv
// dm_store_buffer
//   Store buffer between the MEM stage and the data-memory write port.
//   Stores are queued in a DEPTH-entry circular FIFO and drained one per cycle
//   whenever the DM write port is free. Loads are compared against the pending
//   stores by word address (bits [11:2]). A match raises a stall.
//
//   Optional feature (macro STB_FWD_EN): if the youngest matching entry is a
//   word store, its data is forwarded to the load instead of stalling.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   st_valid/ready   store handshake from MEM stage
//   st_addr/type/data/pc  store payload (type 0 word, 1 half, 3 byte)
//   st_err           store rejected (bad type or misaligned), never enqueued
//   ld_valid/addr    load being checked against pending stores
//   ld_hit           load must stall
//   ld_fwd_valid/data  forwarded word (feature build only, else tied 0)
//   dm_ready         DM write port free this cycle
//   dm_wr            write strobe; dm_addr/type/wd/pc carry the head entry
//   count, empty     number of pending entries, count == 0
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [31:0]        st_addr,
  input  logic [2:0]         st_type,
  input  logic [31:0]        st_data,
  input  logic [31:0]        st_pc,
  output logic               st_err,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  output logic               ld_hit,
  output logic               ld_fwd_valid,
  output logic [31:0]        ld_fwd_data,
  input  logic               dm_ready,
  output logic               dm_wr,
  output logic [31:0]        dm_addr,
  output logic [2:0]         dm_type,
  output logic [31:0]        dm_wd,
  output logic [31:0]        dm_pc,
  output logic [PTR_W:0]     count,
  output logic               empty
);

  localparam logic [2:0] TypeWord = 3'd0;
  localparam logic [2:0] TypeHalf = 3'd1;
  localparam logic [2:0] TypeByte = 3'd3;

  logic [31:0]      r_addr [DEPTH];
  logic [2:0]       r_type [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_type_bad;
  logic             w_misaligned;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_match_any;
  logic [PTR_W-1:0] w_idx;
  logic             w_unused_ld;

  // Store validity check
  always_comb begin
    w_type_bad   = !((st_type == TypeWord) || (st_type == TypeHalf) || (st_type == TypeByte));
    w_misaligned = ((st_type == TypeWord) && (st_addr[1:0] != 2'b00)) ||
                   ((st_type == TypeHalf) && st_addr[0]);
  end

  assign st_err   = st_valid && (w_type_bad || w_misaligned);
  // No push-through: a full buffer refuses even if the head drains this cycle.
  assign st_ready = (r_count != (PTR_W + 1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = st_valid && st_ready && !st_err;
  // Gating on reset keeps discarded stores from reaching DM in the reset cycle.
  assign w_pop    = !w_empty && dm_ready && !reset;

  assign dm_wr   = w_pop;
  assign dm_addr = r_addr[r_rd_ptr];
  assign dm_type = r_type[r_rd_ptr];
  assign dm_wd   = r_data[r_rd_ptr];
  assign dm_pc   = r_pc[r_rd_ptr];
  assign count   = r_count;
  assign empty   = w_empty;

  // Entry storage; contents need no reset since validity comes from count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_type[r_wr_ptr] <= st_type;
      r_data[r_wr_ptr] <= st_data;
      r_pc[r_wr_ptr]   <= st_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_unused_ld = ^{ld_addr[31:12], ld_addr[1:0]};

`ifdef STB_FWD_EN
  logic        w_young_word;
  logic [31:0] w_young_data;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    w_match_any  = 1'b0;
    w_young_word = 1'b0;
    w_young_data = '0;
    w_idx        = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (((PTR_W + 1)'(k) < r_count) && (r_addr[w_idx][11:2] == ld_addr[11:2])) begin
        w_match_any  = 1'b1;
        w_young_word = (r_type[w_idx] == TypeWord);
        w_young_data = r_data[w_idx];
      end
    end
  end

  assign ld_fwd_valid = ld_valid && w_match_any && w_young_word;
  assign ld_fwd_data  = ld_fwd_valid ? w_young_data : 32'b0;
  assign ld_hit       = ld_valid && w_match_any && !w_young_word;
`else
  // Any valid entry in the same word forces a stall; the popping head counts.
  always_comb begin
    w_match_any = 1'b0;
    w_idx       = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (((PTR_W + 1)'(k) < r_count) && (r_addr[w_idx][11:2] == ld_addr[11:2])) begin
        w_match_any = 1'b1;
      end
    end
  end

  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'b0;
  assign ld_hit       = ld_valid && w_match_any;
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Testbench for dm_store_buffer: directed steps followed by randomized traffic,
// all checked against a queue-based reference model.
module tb_dm_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_type;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        dm_ready;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [2:0]  dm_type;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [PTR_W:0] count;
  logic        empty;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_type(st_type),
    .st_data(st_data), .st_pc(st_pc), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .dm_ready(dm_ready), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_type(dm_type),
    .dm_wd(dm_wd), .dm_pc(dm_pc), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  typ;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic m_push;
  logic m_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the model just before the next rising edge.
  task automatic look();
    logic exp_err, exp_ready, match, yw;
    logic [31:0] yd;
    int n;
    @(negedge clk);
    n = q.size();
    exp_err = st_valid && (!(st_type == 3'd0 || st_type == 3'd1 || st_type == 3'd3) ||
                           (st_type == 3'd0 && st_addr[1:0] != 2'b00) ||
                           (st_type == 3'd1 && st_addr[0]));
    exp_ready = (n != DEPTH);
    m_pop  = (n > 0) && dm_ready && !reset;
    m_push = st_valid && exp_ready && !exp_err;
    chk("st_err", {31'b0, st_err}, {31'b0, exp_err});
    chk("st_ready", {31'b0, st_ready}, {31'b0, exp_ready});
    chk("dm_wr", {31'b0, dm_wr}, {31'b0, m_pop});
    chk("count", 32'(count), 32'(n));
    chk("empty", {31'b0, empty}, {31'b0, n == 0});
    if (m_pop) begin
      chk("dm_addr", dm_addr, q[0].addr);
      chk("dm_type", {29'b0, dm_type}, {29'b0, q[0].typ});
      chk("dm_wd", dm_wd, q[0].data);
      chk("dm_pc", dm_pc, q[0].pc);
    end
    match = 1'b0; yw = 1'b0; yd = '0;
    for (int i = 0; i < n; i++) begin
      if (q[i].addr[11:2] == ld_addr[11:2]) begin
        match = 1'b1; yw = (q[i].typ == 3'd0); yd = q[i].data;
      end
    end
`ifdef STB_FWD_EN
    chk("ld_hit", {31'b0, ld_hit}, {31'b0, ld_valid && match && !yw});
    chk("ld_fwd_valid", {31'b0, ld_fwd_valid}, {31'b0, ld_valid && match && yw});
    if (ld_valid && match && yw) chk("ld_fwd_data", ld_fwd_data, yd);
`else
    chk("ld_hit", {31'b0, ld_hit}, {31'b0, ld_valid && match});
    chk("ld_fwd_valid", {31'b0, ld_fwd_valid}, 32'b0);
    chk("ld_fwd_data", ld_fwd_data, 32'b0);
`endif
  endtask

  task automatic adv();
    ent_t e;
    e.addr = st_addr; e.typ = st_type; e.data = st_data; e.pc = st_pc;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d);
    st_valid = v; st_type = t; st_addr = a; st_data = d; st_pc = a ^ 32'h8000_0000;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; dm_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    drive_st(1'b0, 3'd0, 32'h0, 32'h0);
    m_push = 1'b0; m_pop = 1'b0;
    #1;
    adv(); adv();
    reset = 1'b0;
    look();
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    adv();

    // Single store, drains the cycle after the push
    dm_ready = 1'b1;
    drive_st(1'b1, 3'd0, 32'h10, 32'h1122_3344);
    look(); chk("tp1_nobypass", {31'b0, dm_wr}, 32'd0); adv();
    st_valid = 1'b0;
    look();
    chk("tp1_wr", {31'b0, dm_wr}, 32'd1);
    chk("tp1_addr", dm_addr, 32'h10);
    chk("tp1_wd", dm_wd, 32'h1122_3344);
    chk("tp1_type", {29'b0, dm_type}, 32'd0);
    adv();
    look(); chk("tp1_empty", {31'b0, empty}, 32'd1); adv();

    // Fill, refuse a fifth, then drain in order across the pointer wrap
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 3'd0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      look(); adv();
    end
    drive_st(1'b1, 3'd0, 32'h200, 32'hDEAD);
    look();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", {31'b0, st_ready}, 32'd0);
    adv();
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("drain_addr", dm_addr, 32'h100 + 32'(4 * i));
      adv();
      st_valid = 1'b0;
    end
    drive_st(1'b1, 3'd1, 32'h300, 32'h55AA);
    look(); adv();
    st_valid = 1'b0;
    look(); chk("wrap_addr", dm_addr, 32'h300); adv();

    // Error checks
    dm_ready = 1'b0;
    drive_st(1'b1, 3'd1, 32'h21, 32'h1);
    look(); chk("sh_mis", {31'b0, st_err}, 32'd1); adv();
    drive_st(1'b1, 3'd0, 32'h22, 32'h2);
    look(); chk("sw_mis", {31'b0, st_err}, 32'd1); adv();
    drive_st(1'b1, 3'd3, 32'h23, 32'h3);
    look(); chk("sb_ok", {31'b0, st_err}, 32'd0); adv();
    st_valid = 1'b0;
    look(); chk("err_count", 32'(count), 32'd1); adv();
    dm_ready = 1'b1; look(); adv();

    // Load hit on same word only
    dm_ready = 1'b0;
    drive_st(1'b1, 3'd3, 32'h40, 32'h77);
    look(); adv();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h43;
    look(); chk("ld_same", {31'b0, ld_hit}, 32'd1); adv();
    ld_addr = 32'h44;
    look(); chk("ld_next", {31'b0, ld_hit}, 32'd0); adv();
    ld_valid = 1'b0; dm_ready = 1'b1; look(); adv();

    // Youngest-match selection: sb then sw, then sw then sb
    for (int ord = 0; ord < 2; ord++) begin
      dm_ready = 1'b0;
      if (ord == 0) drive_st(1'b1, 3'd3, 32'h80, 32'hAB);
      else          drive_st(1'b1, 3'd0, 32'h80, 32'hCAFE_F00D);
      look(); adv();
      if (ord == 0) drive_st(1'b1, 3'd0, 32'h80, 32'hCAFE_F00D);
      else          drive_st(1'b1, 3'd3, 32'h80, 32'hAB);
      look(); adv();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h80;
      look();
`ifdef STB_FWD_EN
      if (ord == 0) begin
        chk("fwd_valid", {31'b0, ld_fwd_valid}, 32'd1);
        chk("fwd_data", ld_fwd_data, 32'hCAFE_F00D);
        chk("fwd_nohit", {31'b0, ld_hit}, 32'd0);
      end else begin
        chk("fwd_rev_hit", {31'b0, ld_hit}, 32'd1);
        chk("fwd_rev_valid", {31'b0, ld_fwd_valid}, 32'd0);
      end
`else
      chk("nofwd_hit", {31'b0, ld_hit}, 32'd1);
`endif
      adv();
      ld_valid = 1'b0; dm_ready = 1'b1;
      look(); adv(); look(); adv();
    end

    // Reset with pending stores and a ready DM port
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(1'b1, 3'd0, 32'h500 + 32'(4 * i), 32'(i));
      look(); adv();
    end
    st_valid = 1'b0; dm_ready = 1'b1; reset = 1'b1;
    look(); chk("rst_nowr", {31'b0, dm_wr}, 32'd0); adv();
    reset = 1'b0;
    look();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready2", {31'b0, st_ready}, 32'd1);
    chk("rst_nowr2", {31'b0, dm_wr}, 32'd0);
    adv();

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      reset = ($urandom_range(0, 59) == 0);
      r = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2: st_type = 3'd0;
        3, 4, 5: st_type = 3'd1;
        6, 7, 8: st_type = 3'd3;
        default: st_type = r[2:0];
      endcase
      st_valid = r[3];
      st_addr  = {r[31:12], 6'b0, 6'($urandom_range(0, 63))};
      st_data  = $urandom();
      st_pc    = $urandom();
      dm_ready = ($urandom_range(0, 2) == 0);
      ld_valid = r[4];
      r = $urandom();
      ld_addr  = {r[31:12], 6'b0, 6'($urandom_range(0, 63))};
      look(); adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
